// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions: ImmSel encodings, err bit positions,
// buffered result layout and the sign-extension range helper.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_J = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  // err = {bad_sel, misaligned, out_of_range}
  localparam int ERR_OOR = 0;
  localparam int ERR_MIS = 1;
  localparam int ERR_SEL = 2;

  typedef struct packed {
    logic [24:0] data;
    logic [2:0]  err;
  } imm_enc_t;

  // True when v[31:msb] are all equal, i.e. v is a sign extension of v[msb:0].
  function automatic logic fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_encode_core.sv
// Combinational immediate-to-instruction-field mapping with range and
// alignment checks. Truncated bits are still emitted when a flag is raised.
module imm_encode_core
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_sel,
  output logic [24:0] data_o,
  output logic [2:0]  err_o
);

  // Place immediate bits into instruction bits [31:7] per format, flag problems
  always_comb begin
    data_o = '0;
    err_o  = '0;
    case (imm_sel)
      IMM_I: begin
        data_o         = {imm[11], imm[10:0], 13'b0};
        err_o[ERR_OOR] = !fits(imm, 11);
      end
      IMM_J: begin
        data_o         = {imm[20], imm[10:1], imm[11], imm[19:12], 5'b0};
        err_o[ERR_OOR] = !fits(imm, 20);
        err_o[ERR_MIS] = imm[0];
      end
      IMM_S: begin
        data_o         = {imm[11], imm[10:5], 13'b0, imm[4:0]};
        err_o[ERR_OOR] = !fits(imm, 11);
      end
      IMM_U: begin
        data_o         = {imm[19:0], 5'b0};
        err_o[ERR_OOR] = !fits(imm, 19);
      end
      IMM_B: begin
        data_o         = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11]};
        err_o[ERR_OOR] = !fits(imm, 12);
        err_o[ERR_MIS] = imm[0];
      end
      default: err_o[ERR_SEL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: encode core feeding a small result FIFO with
// valid/ready handshakes on both sides and a saturating flagged-request count.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm,
  input  logic [2:0]  ImmSel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] dataOut,
  output logic [2:0]  err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [24:0]   enc_data;
  logic [2:0]    enc_err;
  imm_enc_t      mem_q [FIFO_DEPTH];
  imm_enc_t      mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rdy_q;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          accept, retire;

  imm_encode_core u_core (
    .imm     (imm),
    .imm_sel (ImmSel),
    .data_o  (enc_data),
    .err_o   (enc_err)
  );

  // rdy_q keeps in_ready low throughout reset and for the release cycle
  assign in_ready  = rdy_q && (cnt_q != DEPTH_C);
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign dataOut   = mem_q[rd_ptr_q].data;
  assign err       = mem_q[rd_ptr_q].err;
  assign err_cnt   = err_cnt_q;

  // FIFO next state: write at tail, pop at head, occupancy tracks the net change
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      mem_d[wr_ptr_q] = '{data: enc_data, err: enc_err};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (retire) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (accept && !retire)      cnt_d = cnt_q + CNT_ONE;
    else if (!accept && retire) cnt_d = cnt_q - CNT_ONE;
  end

  // Flagged-request counter: clear wins, otherwise saturating increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (accept && (enc_err != '0) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  // State registers; reset empties the buffer so nothing stale survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rdy_q     <= 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized traffic
// with backpressure, checked by a queue scoreboard and an ImmGen decoder.
module tb_imm_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] imm;
  logic [2:0]  ImmSel;
  logic        out_valid, out_ready;
  logic [24:0] dataOut;
  logic [2:0]  err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  imm_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .ImmSel(ImmSel), .out_valid(out_valid), .out_ready(out_ready),
    .dataOut(dataOut), .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [2:0] sel; logic [31:0] imm; } txn_t;
  txn_t q[$];
  int   cnt_m    = 0;
  bit   rdy_m    = 0;
  int   acc_n    = 0;
  int   sat_hits = 0;

  // Signed width of each format's immediate
  function automatic int fmt_w(input logic [2:0] sel);
    case (sel)
      3'd1: return 21;
      3'd3: return 20;
      3'd4: return 13;
      default: return 12;
    endcase
  endfunction

  function automatic logic [2:0] exp_err(input logic [2:0] sel, input logic [31:0] v);
    int w, s, lo, hi;
    logic oor, mis;
    if (sel > 3'd4) return 3'b100;
    w   = fmt_w(sel);
    s   = $signed(v);
    lo  = -(1 << (w - 1));
    hi  = (1 << (w - 1)) - 1;
    oor = (s < lo) || (s > hi);
    mis = ((sel == 3'd1) || (sel == 3'd4)) && v[0];
    return {1'b0, mis, oor};
  endfunction

  // What the decoder must recover: imm truncated to the format's width,
  // with bit 0 dropped for the halfword-aligned formats
  function automatic logic [31:0] trunc_exp(input logic [2:0] sel, input logic [31:0] v);
    int w;
    logic [31:0] r;
    w = fmt_w(sel);
    r = 32'($signed(v << (32 - w)) >>> (32 - w));
    if ((sel == 3'd1) || (sel == 3'd4)) r[0] = 1'b0;
    return r;
  endfunction

  // ImmGen: decode instruction bits [31:7] back to the immediate
  function automatic logic [31:0] immgen(input logic [2:0] sel, input logic [24:0] d);
    logic [31:0] ins;
    ins = {d, 7'b0};
    case (sel)
      3'd0: return {{20{ins[31]}}, ins[31:20]};
      3'd1: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd2: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd3: return {{12{ins[31]}}, ins[31:12]};
      3'd4: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Instruction bits the format leaves unused (must read zero)
  function automatic logic [24:0] zero_mask(input logic [2:0] sel);
    case (sel)
      3'd0: return 25'h0001FFF;
      3'd2, 3'd4: return 25'h003FFE0;
      default: return 25'h000001F;
    endcase
  endfunction

  // Monitor/scoreboard, sampled mid-cycle away from the active edge
  always @(negedge clk) begin
    txn_t t;
    logic [2:0] e;
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_dataOut", 32'(dataOut), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_err_cnt", 32'(err_cnt), 32'(0));
      q.delete();
      cnt_m = 0;
      rdy_m = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(rdy_m && (q.size() < DEPTH)));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("err_cnt", 32'(err_cnt), 32'(cnt_m));
      if (q.size() != 0) begin
        t = q[0];
        e = exp_err(t.sel, t.imm);
        chk("head_err", 32'(err), 32'(e));
        if (e[2]) chk("badsel_data", 32'(dataOut), 32'(0));
        else begin
          chk("roundtrip", immgen(t.sel, dataOut), trunc_exp(t.sel, t.imm));
          chk("unused_bits", 32'(dataOut & zero_mask(t.sel)), 32'(0));
        end
        if (out_valid && out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back('{sel: ImmSel, imm: imm});
        acc_n++;
      end
      if (err_clr) cnt_m = 0;
      else if (in_valid && in_ready && exp_err(ImmSel, imm) != 3'b0) begin
        if (cnt_m == 255) sat_hits++;
        else cnt_m++;
      end
      rdy_m = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] sel, input logic [31:0] v);
    @(posedge clk); #1;
    in_valid = 1'b1; ImmSel = sel; imm = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_imm(output logic [2:0] sel, output logic [31:0] v);
    logic [31:0] b;
    int k;
    sel = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    case ($urandom % 4)
      0: v = $urandom;
      1: v = 32'($signed($urandom) >>> $urandom_range(11, 31));
      2: begin
        b = 32'd1 << (fmt_w(sel) - 1);
        k = $urandom % 4;
        v = (k == 0) ? b - 32'd1 : (k == 1) ? ~b + 32'd1 : (k == 2) ? b : ~b;
      end
      default: v = 32'($signed($urandom) >>> 20);
    endcase
  endtask

  initial begin
    int start, cyc;
    logic [2:0] s;
    logic [31:0] v;
    rst = 1'b1; in_valid = 1'b0; imm = '0; ImmSel = '0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(in_ready), 32'(1));

    // Directed format cases
    out_ready = 1'b1;
    send(3'd0, 32'hFFFF_F800);
    chk("i_neg_data", 32'(dataOut), 32'h100_0000);
    chk("i_neg_err", 32'(err), 32'(0));
    send(3'd0, 32'h0000_0800);
    chk("i_oor_err", 32'(err), 32'(1));
    chk("i_oor_cnt", 32'(err_cnt), 32'(1));
    send(3'd4, 32'h0000_0FFE);
    chk("b_data", 32'(dataOut), 32'h0FC_001F);
    chk("b_err", 32'(err), 32'(0));
    send(3'd4, 32'h0000_0003);
    chk("b_mis_err", 32'(err), 32'(2));
    send(3'd6, 32'h1234_5678);
    chk("badsel_data_d", 32'(dataOut), 32'(0));
    chk("badsel_err_d", 32'(err), 32'(4));

    // Backpressure: two accepts fill the buffer, then order on release
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; ImmSel = 3'd0; imm = 32'd10;
    @(posedge clk); #1 imm = 32'd11;
    @(posedge clk); #1 imm = 32'd12;
    @(posedge clk); #1 imm = 32'd13;
    @(posedge clk); #1;
    chk("bp_full_ready", 32'(in_ready), 32'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", 32'(dataOut), 32'h0001_4000);
    @(negedge clk);
    chk("bp_second", 32'(dataOut), 32'h0001_6000);

    // Reset with two entries buffered
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; ImmSel = 3'd0; imm = 32'd20;
    @(posedge clk); #1 imm = 32'd21;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    rst = 1'b1;
    #1 chk("rst_async_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'(0));
    end

    // Randomized traffic with backpressure
    start = acc_n;
    cyc   = 0;
    while ((acc_n - start) < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      rand_imm(s, v);
      ImmSel    = s;
      imm       = v;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      err_clr   = ($urandom % 3000) == 0;
      cyc++;
    end
    chk("rand_budget", 32'(cyc < 60000), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("drained", 32'(q.size()), 32'(0));
    chk("saturation_hit", 32'(sat_hits != 0), 32'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
